// File: rtl/lab_pkg.sv
// ---------------------------------------------------------------------------
// lab_pkg
// Shared definitions for the lab button/counter datapath.
//   - state_e          : debouncer FSM state encoding (2 bits)
//   - STABLE_CNT_SIM   : short stability window used in simulation
//   - STABLE_CNT_BOARD : stability window for the real board clock
// ---------------------------------------------------------------------------
package lab_pkg;

    typedef enum logic [1:0] {
        ST_IDLE_LOW  = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_IDLE_HIGH = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_e;

    localparam int STABLE_CNT_SIM   = 4;
    localparam int STABLE_CNT_BOARD = 1000;

endpackage : lab_pkg

// File: rtl/btn_debounce_enable_if.sv
// ---------------------------------------------------------------------------
// btn_debounce_enable_if
// Groups the button input and the conditioned outputs of the debouncer.
//   btn_in     : raw asynchronous button/switch level
//   btn_level  : debounced stable level
//   btn_rise   : one-cycle pulse on debounced 0->1
//   btn_fall   : one-cycle pulse on debounced 1->0
//   enable_out : toggle output driving the counter enable
// Modports:
//   slave  : the debouncer (consumes btn_in, produces the rest)
//   master : the board / environment side
// ---------------------------------------------------------------------------
interface btn_debounce_enable_if;

    logic btn_in;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic enable_out;

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output enable_out
    );

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  enable_out
    );

endinterface : btn_debounce_enable_if

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-flop synchronizer for a single asynchronous level into the clk
// domain. Reused for any asynchronous board input.
//   clk   : destination clock, rising edge
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d_i   : asynchronous input level
//   q_o   : synchronized level (last stage)
// Parameter STAGES: number of flops in the chain (2..3).
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: state is updated with non-blocking assignments so every flop in
    // the chain samples the value its predecessor held before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/btn_debounce_enable.sv
// ---------------------------------------------------------------------------
// btn_debounce_enable
// Conditions a bouncing pushbutton into a clean level plus single-cycle
// rise/fall pulses, and toggles enable_out on every accepted press.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   btn   : btn_debounce_enable_if.slave (btn_in in; btn_level, btn_rise,
//           btn_fall, enable_out out; all outputs registered)
// A new level is accepted only after STABLE_CNT consecutive synchronized
// samples agree; any reversal during the wait restarts acceptance.
// ---------------------------------------------------------------------------
module btn_debounce_enable
    import lab_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = STABLE_CNT_BOARD,
    parameter int CNT_W       = 16,
    parameter bit ENABLE_INIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    btn_debounce_enable_if.slave  btn
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             enable_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (btn.btn_in),
        .q_o   (s)
    );

    // The counter holds the number of consecutive samples seen at the new
    // level; entering a WAIT state already counts the first one, so the
    // accept compare at STABLE_CNT-1 means STABLE_CNT samples in total.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE_LOW;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            enable_q <= ENABLE_INIT;
        end else begin
            // Pulses default low so they last exactly one cycle.
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                ST_IDLE_LOW: begin
                    if (s) begin
                        state_q <= ST_WAIT_HIGH;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!s) begin
                        state_q <= ST_IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= ST_IDLE_HIGH;
                        cnt_q    <= '0;
                        level_q  <= 1'b1;
                        rise_q   <= 1'b1;
                        enable_q <= ~enable_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_IDLE_HIGH: begin
                    if (!s) begin
                        state_q <= ST_WAIT_LOW;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT_LOW: begin
                    if (s) begin
                        state_q <= ST_IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Release never touches enable_out.
                        state_q <= ST_IDLE_LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign btn.btn_level  = level_q;
    assign btn.btn_rise   = rise_q;
    assign btn.btn_fall   = fall_q;
    assign btn.enable_out = enable_q;

endmodule : btn_debounce_enable

// File: doc/btn_debounce_enable.md
Name: btn_debounce_enable

Overview:
Upstream stage for the lab 4-bit counter. It conditions a raw, bouncing pushbutton or switch into a clean level and single-cycle edge pulses, and generates the counter's `enable` as a toggle flip-flop.
- The toggle flips on each debounced press.
- Sits between the board button pin and the counter's `enable` input, in the same clock domain.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on btn_in (legal: 2..3)
- STABLE_CNT, 1000, consecutive synchronized samples required to accept a new level (legal: >=2)
- CNT_W, 16, width of the stability counter (must satisfy 2**CNT_W > STABLE_CNT)
- ENABLE_INIT, 1, reset value of enable_out

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- btn_in  input  1  raw asynchronous button/switch level
- btn_level  output  1  debounced stable level
- btn_rise  output  1  one-cycle pulse on debounced 0->1
- btn_fall  output  1  one-cycle pulse on debounced 1->0
- enable_out  output  1  toggle output, drives counter enable

Behaviour:
- Reset (reset=0, asynchronous): all synchronizer flops=0, state=IDLE_LOW, cnt=0, btn_level=0, btn_rise=0, btn_fall=0, enable_out=ENABLE_INIT. Deassertion is applied on the next clk edge.
- Synchronizer: btn_in passes through SYNC_STAGES flops; the last stage is `s`. Only `s` is used downstream.
- FSM states:
  - IDLE_LOW: s=1 -> WAIT_HIGH, cnt=1; else stay, cnt=0.
  - WAIT_HIGH:
    - s=0 -> IDLE_LOW, cnt=0, no pulse (glitch rejected).
    - s=1 and cnt==STABLE_CNT-1 -> IDLE_HIGH, cnt=0, btn_level<=1, btn_rise<=1, enable_out<=~enable_out.
    - Otherwise cnt<=cnt+1.
  - IDLE_HIGH: s=0 -> WAIT_LOW, cnt=1; else stay.
  - WAIT_LOW: mirror of WAIT_HIGH. Accept -> IDLE_LOW, btn_level<=0, btn_fall<=1. enable_out is unchanged on release.
- All outputs are registered.
  - btn_rise/btn_fall are high for exactly one cycle and then return to 0.
  - btn_rise and btn_fall are never high together.
- Latency: btn_in settles before edge E0. btn_level, pulse and enable_out update at edge E(SYNC_STAGES+STABLE_CNT-1). With SYNC_STAGES=2 this is E(STABLE_CNT+1).
- Bounce: any reversal of s during a WAIT state restarts acceptance from scratch. A pulse of s shorter than STABLE_CNT cycles produces no output change.
- cnt never exceeds STABLE_CNT-1. No wrap is possible.
- Reset mid-WAIT: cnt and state clear immediately. No pulse is emitted.
- btn_in held high through reset release: after release it debounces normally and produces btn_rise and an enable_out toggle.
- Held button: exactly one btn_rise per accepted press, regardless of hold duration.

Decomposition:
- Shared package lab_pkg holds:
  - 2-bit state encodings ST_IDLE_LOW=0, ST_WAIT_HIGH=1, ST_IDLE_HIGH=2, ST_WAIT_LOW=3.
  - Default STABLE_CNT values for simulation (4) and board (1000).
- One sub-module, sync_ff (parameter STAGES, async active-low reset to 0). It is reused for other asynchronous board inputs.
- FSM, counter and output registers live in btn_debounce_enable.

Test Plan (STABLE_CNT=4, SYNC_STAGES=2, ENABLE_INIT=1, 10 ns clk):
1. Reset, then btn_in 0->1 just before edge E0, held -> btn_level=1 and btn_rise=1 after E5; btn_rise=0 after E6; enable_out 1->0 after E5.
2. Press with bounce: btn_in high 2 cycles, low 1 cycle, then high steady -> no btn_rise during the bounce. Single btn_rise 5 edges after the final rise; exactly one enable_out toggle.
3. Release: held-high btn_in goes low and is held -> btn_fall one cycle at E5 after the change; btn_level=0; enable_out unchanged.
4. Glitch: btn_in high for 3 cycles only -> btn_level, btn_rise and enable_out unchanged throughout.
5. Two clean presses separated by 20 cycles -> enable_out 1->0->1; exactly two btn_rise and two btn_fall pulses.
6. Assert reset during WAIT_HIGH (cnt=2) -> outputs immediately at reset values and enable_out=1. With btn_in still high after release, btn_rise arrives 5 edges after release.
